xgriscv_muldiv: RTL
===================

Name: xgriscv_muldiv

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the xgriscv pipeline. It sits beside the single-cycle ALU in EX. The hazard unit stalls the pipeline while the unit is busy. Operands arrive over a valid/ready handshake; a radix-2 shift-add multiplier and a restoring divider share one datapath and produce one result per operation, held until accepted.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNTW, $clog2(XLEN)+1, iteration counter width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
flush  in  1  kill in-flight operation (branch/exception)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  result
busy  out  1  state != IDLE, used for the stall

Behaviour:
- Clock is clk. Reset is rstn, synchronous and active-low; it is sampled on the rising clk edge. Reset while rstn=0: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1. All internal registers are cleared.
- Reset mid-operation aborts the operation. No out_valid follows it.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid=1 and flush=0, latch op, sign flags and operand magnitudes.
  - If a special case applies: go to DONE with the result.
  - Otherwise: go to BUSY with cnt=XLEN.
- BUSY: in_ready=0. One iteration per cycle, then cnt decrements. At cnt==1, compute the sign-corrected result and go to DONE.
- DONE: out_valid=1 and result is stable. If out_ready=1, go to IDLE. in_ready stays 0 in DONE; there is no back-to-back accept in the same cycle.
- Latency: the request is accepted in cycle T.
  - Iterative case: out_valid is asserted in cycle T+XLEN+1.
  - Special case: out_valid is asserted in cycle T+1.
- flush=1 in BUSY or DONE: go to IDLE next cycle with out_valid=0 and no result. flush=1 in IDLE blocks acceptance.
- flush has priority over out_ready and in_valid. rstn has priority over everything.
- Multiply:
  - Operands are converted to magnitudes; a is signed for MULH and MULHSU, b is signed for MULH only.
  - A 2*XLEN product is accumulated by shift-add.
  - If the sign flags differ, the full 2*XLEN product is negated (two's complement).
  - MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Signed ops use magnitudes.
  - Restoring division: shift a dividend bit into the partial remainder, trial-subtract the divisor, and keep the result if it is non-negative.
  - The quotient is negated if the operand signs differ (DIV). The remainder takes the dividend's sign (REM).
- Special cases (single cycle, no iterations):
  - b==0: DIV/DIVU result is all ones; REM/REMU result is a.
  - DIV or REM with a=most-negative (1<<XLEN-1) and b=-1: DIV result is a, REM result is 0.
- No exceptions are raised; the results above follow the RISC-V spec.
- in_valid while busy is ignored. The requester must hold its request until in_ready.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: all four multiply ops use a combinational XLEN x XLEN signed/unsigned multiplier, and the result is registered directly into DONE. Multiply latency is T+1 and BUSY is never entered for multiplies.
- Undefined: multiplies use the iterative path, with latency T+XLEN+1.
- Divides are identical in both builds.

Test Plan:
- XLEN=32, MUL a=7 b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB. out_valid exactly 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN). busy high throughout.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5 b=0 -> 0xFFFFFFFF and REM a=5 b=0 -> 5, each with out_valid 1 cycle after accept. DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, and a new in_valid is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- flush at BUSY cycle 5 of a DIV -> IDLE next cycle, no out_valid, next op MUL 3*4 -> 12. Driving rstn=0 at BUSY cycle 10 -> all outputs at reset values on the following edge.

Source files
------------

// File: rtl/xgriscv_muldiv.sv
// xgriscv_muldiv: multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
//
// A radix-2 shift-add multiplier and a restoring divider share a single 2*XLEN
// accumulator. One result is produced per accepted request and is held until the
// consumer takes it.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   - multiplies use a combinational XLEN x XLEN multiplier (1-cycle latency)
//   undefined - multiplies iterate like divides (XLEN+1 cycle latency)
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   request strobe; in_ready high while idle
//   op         funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b       rs1 / rs2 operands
//   flush      kills the in-flight operation; blocks acceptance while idle
//   out_valid  result available; out_ready retires it
//   result     result, stable while out_valid is high
//   busy       unit not idle (pipeline stall)

module xgriscv_muldiv #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   res_q, res_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            a_sgn, b_sgn, a_neg, b_neg, req_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    // a is signed for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM
    a_sgn = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    mag_a = a_neg ? (~a + 1'b1) : a;
    mag_b = b_neg ? (~b + 1'b1) : b;
    // Remainder follows the dividend sign; everything else follows the sign xor
    req_neg = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

    div_by_zero = (b == '0);
    div_ovf     = !op[0] && (a == MinNeg) && (b == '1);
    special     = op[2] && (div_by_zero || div_ovf);
    if (div_by_zero) begin
      special_res = op[1] ? a : '1;
    end else begin
      special_res = op[1] ? '0 : a;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional single-cycle multiplier
  // ---------------------------------------------------------------------------
  logic            fast_mul;
  logic [XLEN-1:0] fast_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;

  // Sign- or zero-extending to 2*XLEN makes the truncated product correct for
  // every signedness combination.
  always_comb begin
    ext_a     = {{XLEN{a_neg}}, a};
    ext_b     = {{XLEN{b_neg}}, b};
    fast_prod = ext_a * ext_b;
    fast_mul  = !op[2];
    fast_res  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  // ---------------------------------------------------------------------------
  // Shared iteration datapath
  // ---------------------------------------------------------------------------
  // Multiply: acc = {partial product, remaining multiplier}, opnd = multiplicand.
  // Divide:   acc = {partial remainder, dividend/quotient},  opnd = divisor.
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic              qbit;
  logic [XLEN-1:0]   new_rem;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] fin_prod;
  logic [XLEN-1:0]   fin_v, fin_div, final_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    qbit    = ~diff[XLEN];
    new_rem = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];

    if (op_q[2]) begin
      step = {new_rem, acc_q[XLEN-2:0], qbit};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end

    // Sign correction applied to the value after the last iteration
    fin_prod = neg_q ? (~step + 1'b1) : step;
    fin_v    = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    fin_div  = neg_q ? (~fin_v + 1'b1) : fin_v;
    if (op_q[2]) begin
      final_res = fin_div;
    end else if (op_q[1:0] == 2'b00) begin
      final_res = fin_prod[XLEN-1:0];
    end else begin
      final_res = fin_prod[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          op_d  = op;
          neg_d = req_neg;
          if (special) begin
            res_d   = special_res;
            state_d = StDone;
          end else if (fast_mul) begin
            res_d   = fast_res;
            state_d = StDone;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            opnd_d  = op[2] ? mag_b : mag_a;
            cnt_d   = CNTW'(XLEN);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            res_d   = final_res;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (flush || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;

endmodule
